// File: rtl/posit_defines.sv
// posit_defines: rounding-mode type and posit special-value constants shared by the posit datapath.
// Constants are produced 64 bits wide; callers size-cast them to their posit width (<= 64 bits).
package posit_defines;

    typedef enum logic {
        RND_RNE   = 1'b0,
        RND_TRUNC = 1'b1
    } rnd_mode_e;

    // Largest finite posit: 0 followed by n-1 ones.
    function automatic logic [63:0] posit_maxpos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Smallest positive posit: only the LSB set.
    function automatic logic [63:0] posit_minpos(input int n);
        return (n > 0) ? 64'd1 : 64'd0;
    endfunction

    // Not-a-Real: 1 followed by n-1 zeros.
    function automatic logic [63:0] posit_nar(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/shift_right.sv
// shift_right: logical right shift of a W-bit word, vacated MSBs filled with fill_i.
// Ports: data_i word in, fill_i bit shifted in from the top, shamt_i shift distance, data_o shifted word.
module shift_right #(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic [W-1:0]   data_i,
    input  logic           fill_i,
    input  logic [SHW-1:0] shamt_i,
    output logic [W-1:0]   data_o
);
    // Prepending the fill bit as a sign makes an arithmetic shift replicate it.
    always_comb data_o = W'($signed({fill_i, data_i}) >>> shamt_i);
endmodule

// File: rtl/posit_normalize_accum_pipe.sv
// posit_normalize_accum_pipe: 3-stage pipeline encoding a normalized (sign, scale, fraction) value as a posit.
// Ports: clk/reset (async, active-high); in_* input beat with in_valid/in_ready handshake;
//        rnd_mode 0 = round-nearest-even, 1 = truncate; out_valid/out_ready output handshake;
//        result encoded posit, out_inf NaR flag, out_zero zero flag.
module posit_normalize_accum_pipe
    import posit_defines::*;
#(
    parameter int NBITS = 32,
    parameter int ES    = 3,
    parameter int FBITS = 252,
    parameter int SW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sgn,
    input  logic signed [SW-1:0] in_scale,
    input  logic [FBITS-1:0]     in_fraction,
    input  logic                 in_truncated,
    input  logic                 in_inf,
    input  logic                 in_zero,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NBITS-1:0]     result,
    output logic                 out_inf,
    output logic                 out_zero
);
    localparam int SHW = $clog2(NBITS);
    // NBITS zero pad bits at the bottom keep every shifted-out bit inside the word for the sticky OR.
    localparam int L   = 2 + ES + FBITS + NBITS;
    localparam logic [NBITS-1:0] MAXPOS = NBITS'(posit_maxpos(NBITS));
    localparam logic [NBITS-1:0] MINPOS = NBITS'(posit_minpos(NBITS));
    localparam logic [NBITS-1:0] NAR    = NBITS'(posit_nar(NBITS));
    localparam logic signed [SW-1:0] SAT_HI = SW'((NBITS - 2) << ES);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-((NBITS - 2) << ES));

    logic ld1, ld2, ld3;
    logic v1_q, v2_q, v3_q;
    assign ld3       = ~v3_q | out_ready;
    assign ld2       = ~v2_q | ld3;
    assign ld1       = ~v1_q | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3_q;

    // S1: regime run length and saturation
    logic signed [SW-1:0] k;
    logic [SHW-1:0]   s1_sh_d, s1_sh_q;
    logic             s1_hi_d, s1_lo_d, s1_hi_q, s1_lo_q, s1_neg_q;
    logic             s1_sgn_q, s1_trunc_q, s1_inf_q, s1_zero_q;
    rnd_mode_e        s1_rnd_q;
    logic [ES-1:0]    s1_e_q;
    logic [FBITS-1:0] s1_frac_q;
    always_comb begin
        k       = in_scale >>> ES;
        // Shift past the two seed regime bits: k for positive regimes, -k-1 (= ~k) for negative ones.
        s1_sh_d = SHW'(k[SW-1] ? ~k : k);
        s1_hi_d = in_scale >= SAT_HI;
        s1_lo_d = in_scale < SAT_LO;
    end

    // S2: build the regime by shifting a two-bit seed with the regime fill bit
    logic [L-1:0]     s2_x, s2_xs;
    logic [NBITS-1:0] s2_mag_d, s2_mag_q;
    logic             s2_ba_d, s2_st_d, s2_ba_q, s2_st_q;
    logic             s2_hi_q, s2_lo_q, s2_sgn_q, s2_inf_q, s2_zero_q;
    rnd_mode_e        s2_rnd_q;
    assign s2_x = {~s1_neg_q, s1_neg_q, s1_e_q, s1_frac_q, {NBITS{1'b0}}};
    shift_right #(.W(L), .SHW(SHW)) u_regime (
        .data_i (s2_x),
        .fill_i (~s1_neg_q),
        .shamt_i(s1_sh_q),
        .data_o (s2_xs)
    );
    always_comb begin
        s2_mag_d = {1'b0, s2_xs[L-1 -: NBITS-1]};
        s2_ba_d  = s2_xs[L-NBITS];
        s2_st_d  = (|s2_xs[L-NBITS-1:0]) | s1_trunc_q;
    end

    // S3: rounding, sign, specials
    logic             inc;
    logic [NBITS-1:0] mag, res_d, res_q;
    logic             inf_q, zero_q;
    always_comb begin
        inc   = (s2_rnd_q == RND_RNE) & s2_ba_q & (s2_st_q | s2_mag_q[0]) & (s2_mag_q != MAXPOS);
        mag   = s2_hi_q ? MAXPOS : s2_lo_q ? MINPOS : s2_mag_q + NBITS'(inc);
        res_d = s2_inf_q ? NAR : s2_zero_q ? '0 : s2_sgn_q ? -mag : mag;
    end
    assign result   = res_q;
    assign out_inf  = inf_q;
    assign out_zero = zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            s1_sh_q    <= '0;
            s1_hi_q    <= 1'b0;
            s1_lo_q    <= 1'b0;
            s1_neg_q   <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_trunc_q <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_rnd_q   <= RND_RNE;
            s1_e_q     <= '0;
            s1_frac_q  <= '0;
            s2_mag_q   <= '0;
            s2_ba_q    <= 1'b0;
            s2_st_q    <= 1'b0;
            s2_hi_q    <= 1'b0;
            s2_lo_q    <= 1'b0;
            s2_sgn_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_rnd_q   <= RND_RNE;
            res_q      <= '0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q       <= in_valid;
                s1_sh_q    <= s1_sh_d;
                s1_hi_q    <= s1_hi_d;
                s1_lo_q    <= s1_lo_d;
                s1_neg_q   <= in_scale[SW-1];
                s1_sgn_q   <= in_sgn;
                s1_trunc_q <= in_truncated;
                s1_inf_q   <= in_inf;
                s1_zero_q  <= in_zero;
                s1_rnd_q   <= rnd_mode_e'(rnd_mode);
                s1_e_q     <= in_scale[ES-1:0];
                s1_frac_q  <= in_fraction;
            end
            if (ld2) begin
                v2_q      <= v1_q;
                s2_mag_q  <= s2_mag_d;
                s2_ba_q   <= s2_ba_d;
                s2_st_q   <= s2_st_d;
                s2_hi_q   <= s1_hi_q;
                s2_lo_q   <= s1_lo_q;
                s2_sgn_q  <= s1_sgn_q;
                s2_inf_q  <= s1_inf_q;
                s2_zero_q <= s1_zero_q;
                s2_rnd_q  <= s1_rnd_q;
            end
            if (ld3) begin
                v3_q   <= v2_q;
                res_q  <= res_d;
                inf_q  <= s2_inf_q;
                zero_q <= ~s2_inf_q & s2_zero_q;
            end
        end
    end
endmodule

// File: tb/tb_posit_normalize_accum_pipe.sv
// tb_posit_normalize_accum_pipe: directed bench with a bit-string posit model and per-cycle scoreboard.
module tb_posit_normalize_accum_pipe;
    localparam int FB = 252;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sgn = 1'b0, in_truncated = 1'b0;
    logic in_inf = 1'b0, in_zero = 1'b0, rnd_mode = 1'b0, out_ready = 1'b1;
    logic signed [9:0] in_scale = '0;
    logic [FB-1:0] in_fraction = '0;
    logic in_ready, out_valid, out_inf, out_zero;
    logic [31:0] result;

    int n_cmp = 0, n_bad = 0;
    logic [33:0] exp_q[$];
    logic [34:0] held;
    bit stall = 1'b0;
    int sc_tab[8] = '{17, -5, 100, -100, 239, 240, -240, -241};
    logic [FB-1:0] f0, fb, ft, fr;
    int sent, cyc;
    bit acc;

    always #5 clk = ~clk;

    posit_normalize_accum_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sgn(in_sgn),
        .in_scale(in_scale), .in_fraction(in_fraction), .in_truncated(in_truncated),
        .in_inf(in_inf), .in_zero(in_zero), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_inf(out_inf), .out_zero(out_zero)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Posit<32,3> encoding written out as a bit string: regime, exponent, fraction, then round.
    function automatic logic [33:0] model(input logic sg, input int sc, input logic [FB-1:0] f,
                                          input logic tr, input logic nr, input logic zr, input logic rnd);
        bit q[$];
        logic [31:0] mag;
        int k, e;
        logic ba, st;
        if (nr) return {32'h80000000, 2'b10};
        if (zr) return {32'h00000000, 2'b01};
        if (sc >= 240) mag = 32'h7FFFFFFF;
        else if (sc < -240) mag = 32'h00000001;
        else begin
            k = (sc >= 0) ? sc / 8 : -((7 - sc) / 8);
            e = sc - 8 * k;
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
            for (int i = FB - 1; i >= 0; i--) q.push_back(f[i]);
            mag = '0;
            for (int i = 0; i < 31; i++) mag = {mag[30:0], q[i]};
            ba = q[31];
            st = tr;
            for (int i = 32; i < q.size(); i++) st |= q[i];
            if (!rnd && ba && (st || mag[0]) && mag != 32'h7FFFFFFF) mag = mag + 32'd1;
        end
        if (sg) mag = -mag;
        return {mag, 2'b00};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) chk("stall_hold", 64'({out_valid, result, out_inf, out_zero}), 64'(held));
            stall = out_valid && !out_ready;
            held = {out_valid, result, out_inf, out_zero};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: unexpected result %h", result);
                end else chk("sb_result", 64'({result, out_inf, out_zero}), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sgn, int'(in_scale), in_fraction, in_truncated, in_inf, in_zero, rnd_mode));
        end
    end

    task automatic drive(input logic sg, input int sc, input logic [FB-1:0] f,
                         input logic tr, input logic nr, input logic zr, input logic rnd);
        in_sgn = sg;
        in_scale = 10'(sc);
        in_fraction = f;
        in_truncated = tr;
        in_inf = nr;
        in_zero = zr;
        rnd_mode = rnd;
    endtask

    task automatic lit(input string nm, input logic sg, input int sc, input logic [FB-1:0] f,
                       input logic tr, input logic nr, input logic zr, input logic rnd,
                       input logic [31:0] er, input logic ei, input logic ez);
        drive(sg, sc, f, tr, nr, zr, rnd);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 chk({nm, "_lat"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1 chk(nm, 64'({out_valid, result, out_inf, out_zero}), 64'({1'b1, er, ei, ez}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        f0 = '0;
        fb = '0;
        fb[FB-27] = 1'b1;
        ft = fb;
        ft[FB-26] = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_state", 64'({out_valid, result, out_inf, out_zero, in_ready}), 64'({1'b0, 32'h0, 3'b001}));

        lit("scale0_pos",   0,    0, f0, 0, 0, 0, 0, 32'h40000000, 0, 0);
        lit("scale0_neg",   1,    0, f0, 0, 0, 0, 0, 32'hC0000000, 0, 0);
        lit("tie_even",     0,    0, fb, 0, 0, 0, 0, 32'h40000000, 0, 0);
        lit("tie_sticky",   0,    0, fb, 1, 0, 0, 0, 32'h40000001, 0, 0);
        lit("trunc_mode",   0,    0, fb, 1, 0, 0, 1, 32'h40000000, 0, 0);
        lit("tie_odd",      0,    0, ft, 0, 0, 0, 0, 32'h40000002, 0, 0);
        lit("scale1",       0,    1, f0, 0, 0, 0, 0, 32'h44000000, 0, 0);
        lit("scale8",       0,    8, f0, 0, 0, 0, 0, 32'h60000000, 0, 0);
        lit("scale_m1",     0,   -1, f0, 0, 0, 0, 0, 32'h3C000000, 0, 0);
        lit("sat_hi",       0,  300, f0, 0, 0, 0, 0, 32'h7FFFFFFF, 0, 0);
        lit("sat_lo",       0, -300, f0, 0, 0, 0, 0, 32'h00000001, 0, 0);
        lit("sat_hi_neg",   1,  300, f0, 0, 0, 0, 0, 32'h80000001, 0, 0);
        lit("sat_lo_neg",   1, -300, f0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        lit("edge239_trunc",0,  239, f0, 0, 0, 0, 1, 32'h7FFFFFFE, 0, 0);
        lit("edge_m240",    0, -240, f0, 0, 0, 0, 0, 32'h00000001, 0, 0);
        lit("nar_priority", 0,    5, f0, 0, 1, 1, 0, 32'h80000000, 1, 0);
        lit("zero",         1,    5, fb, 1, 0, 1, 0, 32'h00000000, 0, 1);

        sent = 0;
        cyc = 0;
        while (sent < 8 && cyc < 100) begin
            fr = {63{4'(sent * 3 + 5)}};
            drive(sent[0], sc_tab[sent], fr, sent[0] ^ sent[2], 1'b0, 1'b0, sent[1]);
            in_valid = 1'b1;
            out_ready = (cyc % 2 == 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_sent", 64'(sent), 64'(8));
        repeat (12) begin
            out_ready = ~out_ready;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("stream_drained", 64'(exp_q.size()), 64'(0));

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16 * i, f0, 1'b0, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("full_before_rst", 64'({out_valid, in_ready}), 64'(2'b10));
        #2 reset = 1'b1;
        #1 chk("rst_async", 64'({out_valid, result, out_inf, out_zero}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        #1 chk("rdy_after_rst", 64'(in_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("no_ghost", 64'(out_valid), 64'(0));
        end
        lit("post_rst", 0, 8, f0, 0, 0, 0, 0, 32'h60000000, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/posit_normalize_accum_pipe.md
POSIT_NORMALIZE_ACCUM_PIPE -- requirements
Module: posit_normalize_accum_pipe

Interface
REQ-001 SHALL have parameter NBITS, default 32, posit width of the result.
REQ-002 SHALL have parameter ES, default 3, exponent field width.
REQ-003 SHALL have parameter FBITS, default 252, input fraction width (hidden bit excluded, MSB-aligned).
REQ-004 SHALL have parameter SW, default 10, two's-complement width of in_scale.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_sgn  in  1  sign of the value.
- in_scale  in  SW  signed scale (regime*2^ES + exponent).
- in_fraction  in  FBITS  fraction bits below the hidden one.
- in_truncated  in  1  upstream discarded nonzero bits.
- in_inf  in  1  value is NaR.
- in_zero  in  1  value is zero.
- rnd_mode  in  1  sampled with the beat: 0 = round-nearest-even, 1 = truncate magnitude.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- result  out  NBITS  encoded posit.
- out_inf  out  1  result is NaR.
- out_zero  out  1  result is zero (never set together with out_inf).

Function
REQ-007 SHALL be a 3-stage pipeline:
- S1: regime length, exponent, saturation flags.
- S2: regime/exponent/fraction shift, guard bit (bafter), sticky OR.
- S3: rounding, sign application, special-case muxing.
REQ-008 SHALL give latency of exactly 3 cycles from acceptance to out_valid when out_ready is held high.
REQ-009 SHALL sustain a throughput of 1 beat/cycle with out_ready high.
REQ-010 SHALL let each stage load when empty or when the next stage loads; in_ready = S1 loads; bubbles collapse.
REQ-011 SHALL hold result, out_inf, out_zero and out_valid stable while out_valid & ~out_ready.
REQ-012 SHALL saturate when scale >= (NBITS-2)*2^ES: magnitude = maxpos (0 followed by NBITS-1 ones).
REQ-013 SHALL saturate when scale < -(NBITS-2)*2^ES: magnitude = minpos (only LSB set); rounding never yields zero.
REQ-014 SHALL, in RNE mode, increment the magnitude iff bafter & (sticky | blast), where sticky = in_truncated | OR of all bits below bafter.
REQ-015 SHALL, in truncate mode, never increment the magnitude.
REQ-016 SHALL clamp an increment that would reach NaR magnitude at maxpos.
REQ-017 SHALL apply negative sign as the NBITS-bit two's complement of {0, magnitude}.
REQ-018 SHALL give in_inf priority: result = 1 followed by NBITS-1 zeros, out_inf = 1.
REQ-019 SHALL otherwise, for in_zero, give result = 0 and out_zero = 1.

Reset
REQ-020 SHALL, on reset, clear all stage valids: out_valid = 0, result = 0, out_inf = 0, out_zero = 0, in_ready = 1 on the first cycle after release.
REQ-021 SHALL discard in-flight beats on reset mid-operation; no beat emerges after release unless it is accepted after release.

Structure
REQ-022 SHALL place the rounding-mode enum and the maxpos/minpos/NaR constant functions in the shared posit_defines package.
REQ-023 SHALL reuse the existing shift_right module for the S2 regime shift; it is the only sub-module.

Verification
REQ-024 SHALL cover these scenarios (NBITS=32, ES=3):
- in_scale=0, fraction=0, sgn=0 -> result 0x40000000 three cycles later; with sgn=1 -> 0xC0000000.
- in_scale=0, only fraction bit FBITS-27 set, truncated=0, RNE -> 0x40000000 (tie to even); same beat with truncated=1 -> 0x40000001; rnd_mode=1 -> 0x40000000.
- in_scale=+300 -> 0x7FFFFFFF; in_scale=-300 -> 0x00000001; with sgn=1 -> 0x80000001 and 0xFFFFFFFF.
- in_inf=1 with in_zero=1 -> 0x80000000, out_inf=1, out_zero=0; in_zero only -> 0x00000000, out_zero=1.
- 8 back-to-back beats with out_ready toggling 1010... -> all 8 results in order, none dropped or duplicated, outputs stable while stalled.
- reset asserted with 3 beats in flight -> out_valid=0 immediately and stays 0 until a new beat is accepted.
